// File: rtl/groove_pkg.sv
// Shared definitions for the groove preprocess chain: timestamp width, sweep
// direction encoding and the per-pin accept event handed to the top level.
package groove_pkg;

   localparam int   TS_WIDTH = 32;
   localparam logic DIR_LTR  = 1'b0;
   localparam logic DIR_RTL  = 1'b1;

   typedef struct packed {
      logic edge_pulse;
      logic rise;
   } pin_evt_t;

   function automatic logic [TS_WIDTH-1:0] sat_inc(input logic [TS_WIDTH-1:0] v,
                                                   input logic [TS_WIDTH-1:0] lim);
      return (v >= lim) ? lim : v + TS_WIDTH'(1);
   endfunction

endpackage

// File: rtl/groove_pin_filter.sv
// One conditioned input pin: two-flop synchroniser, stability filter and a
// registered edge pulse with polarity. evt_nxt is the same event one cycle early.
module groove_pin_filter
   import groove_pkg::*;
#(
   parameter int FILTER_CYCLES = 4
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     raw,
   output logic     lvl,
   output logic     edge_pulse,
   output logic     rise,
   output pin_evt_t evt_nxt
);

   localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

   logic       s1_r;
   logic       s2_r;
   logic       lvl_r;
   logic       edge_r;
   logic       rise_r;
   logic [7:0] cnt_r;
   logic       accept_s;

   // Accept on the FILTER_CYCLES-th consecutive sample that differs from lvl
   always_comb begin
      accept_s = (s2_r != lvl_r) && (cnt_r == CNT_LAST);
   end

   // Synchroniser, filter counter and registered edge/polarity
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         lvl_r  <= 1'b0;
         cnt_r  <= 8'd0;
         edge_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         s1_r   <= raw;
         s2_r   <= s1_r;
         edge_r <= accept_s;
         rise_r <= accept_s & s2_r;
         if (s2_r == lvl_r) begin
            cnt_r <= 8'd0;
         end else if (accept_s) begin
            lvl_r <= s2_r;
            cnt_r <= 8'd0;
         end else begin
            cnt_r <= cnt_r + 8'd1;
         end
      end
   end

   assign lvl        = lvl_r;
   assign edge_pulse = edge_r;
   assign rise       = rise_r;
   assign evt_nxt    = '{edge_pulse: accept_s, rise: s2_r};

endmodule

// File: rtl/groove_edge_timestamper.sv
// Groove front end: four filtered pins, free-running timestamp, merged sync
// pulse with sweep direction, and the sync-lost watchdog.
module groove_edge_timestamper
   import groove_pkg::*;
#(
   parameter int                  FILTER_CYCLES = 4,
   parameter logic [TS_WIDTH-1:0] SYNC_TIMEOUT  = 32'd5_000_000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sig_l_raw,
   input  logic                sig_r_raw,
   input  logic                lsync_raw,
   input  logic                rsync_raw,
   output logic [TS_WIDTH-1:0] current_timestamp,
   output logic                sig_l_edge,
   output logic                sig_l_rise,
   output logic                sig_r_edge,
   output logic                sig_r_rise,
   output logic                sync_pulse,
   output logic                dir,
   output logic                sync_lost,
   output logic                sync_conflict
);

   logic [TS_WIDTH-1:0] ts_r;
   logic [TS_WIDTH-1:0] wd_r;
   logic [TS_WIDTH-1:0] wd_inc_s;
   logic                sync_pulse_r;
   logic                conflict_r;
   logic                dir_r;
   logic                lost_r;
   logic                l_sync_s;
   logic                r_sync_s;
   logic                sync_s;
   logic                conflict_s;
   logic                dir_nxt_s;
   logic                lost_nxt_s;

   logic     sig_l_lvl_s, sig_r_lvl_s, lsync_lvl_s, rsync_lvl_s;
   logic     lsync_edge_s, lsync_rise_s, rsync_edge_s, rsync_rise_s;
   pin_evt_t sig_l_evt_s, sig_r_evt_s, lsync_evt_s, rsync_evt_s;
   logic     unused_s;

   groove_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sig_l (
      .clk(clk), .reset_n(reset_n), .raw(sig_l_raw), .lvl(sig_l_lvl_s),
      .edge_pulse(sig_l_edge), .rise(sig_l_rise), .evt_nxt(sig_l_evt_s));

   groove_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sig_r (
      .clk(clk), .reset_n(reset_n), .raw(sig_r_raw), .lvl(sig_r_lvl_s),
      .edge_pulse(sig_r_edge), .rise(sig_r_rise), .evt_nxt(sig_r_evt_s));

   groove_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_lsync (
      .clk(clk), .reset_n(reset_n), .raw(lsync_raw), .lvl(lsync_lvl_s),
      .edge_pulse(lsync_edge_s), .rise(lsync_rise_s), .evt_nxt(lsync_evt_s));

   groove_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_rsync (
      .clk(clk), .reset_n(reset_n), .raw(rsync_raw), .lvl(rsync_lvl_s),
      .edge_pulse(rsync_edge_s), .rise(rsync_rise_s), .evt_nxt(rsync_evt_s));

   // Sync events use the filters' early accept so sync_pulse aligns with SIG edges
   always_comb begin
      l_sync_s   = lsync_evt_s.edge_pulse & lsync_evt_s.rise;
      r_sync_s   = rsync_evt_s.edge_pulse & rsync_evt_s.rise;
      sync_s     = l_sync_s | r_sync_s;
      conflict_s = l_sync_s & r_sync_s;
      wd_inc_s   = sat_inc(wd_r, SYNC_TIMEOUT);
      if (l_sync_s && !r_sync_s) begin
         dir_nxt_s = DIR_LTR;
      end else if (r_sync_s && !l_sync_s) begin
         dir_nxt_s = DIR_RTL;
      end else begin
         dir_nxt_s = dir_r;
      end
      if (sync_s) begin
         lost_nxt_s = 1'b0;
      end else begin
         lost_nxt_s = lost_r | (wd_inc_s == SYNC_TIMEOUT);
      end
   end

   // Timestamp, sync outputs, direction and watchdog registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_r         <= '0;
         wd_r         <= '0;
         sync_pulse_r <= 1'b0;
         conflict_r   <= 1'b0;
         dir_r        <= DIR_LTR;
         lost_r       <= 1'b1;
      end else begin
         ts_r         <= ts_r + TS_WIDTH'(1);
         wd_r         <= sync_s ? '0 : wd_inc_s;
         sync_pulse_r <= sync_s;
         conflict_r   <= conflict_s;
         dir_r        <= dir_nxt_s;
         lost_r       <= lost_nxt_s;
      end
   end

   assign current_timestamp = ts_r;
   assign sync_pulse        = sync_pulse_r;
   assign sync_conflict     = conflict_r;
   assign dir               = dir_r;
   assign sync_lost         = lost_r;

   assign unused_s = ^{sig_l_lvl_s, sig_r_lvl_s, lsync_lvl_s, rsync_lvl_s,
                       sig_l_evt_s, sig_r_evt_s, lsync_edge_s, lsync_rise_s,
                       rsync_edge_s, rsync_rise_s};

endmodule

// File: tb/tb_groove_edge_timestamper.sv
// Randomised and directed bench for groove_edge_timestamper against a
// window-based reference model of the pin filters, sync merge and watchdog.
module tb_groove_edge_timestamper;

   localparam int          FC = 4;
   localparam logic [31:0] TO = 32'd50;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sig_l_raw = 1'b0, sig_r_raw = 1'b0, lsync_raw = 1'b0, rsync_raw = 1'b0;
   logic [31:0] current_timestamp;
   logic        sig_l_edge, sig_l_rise, sig_r_edge, sig_r_rise;
   logic        sync_pulse, dir, sync_lost, sync_conflict;

   groove_edge_timestamper #(.FILTER_CYCLES(FC), .SYNC_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .sig_l_raw(sig_l_raw), .sig_r_raw(sig_r_raw),
      .lsync_raw(lsync_raw), .rsync_raw(rsync_raw),
      .current_timestamp(current_timestamp),
      .sig_l_edge(sig_l_edge), .sig_l_rise(sig_l_rise),
      .sig_r_edge(sig_r_edge), .sig_r_rise(sig_r_rise),
      .sync_pulse(sync_pulse), .dir(dir), .sync_lost(sync_lost),
      .sync_conflict(sync_conflict));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: raw history per pin, accepted levels, sync bookkeeping
   bit hist[4][$];
   bit m_lvl[4];
   bit e_edge[4];
   bit e_rise[4];
   bit m_dir, e_sync, e_conf, synced, ts_ok;
   int last_sync;

   // Observation bookkeeping for directed tests
   int tick_no = 0;
   int l_cnt = 0, r_cnt = 0, s_cnt = 0, c_cnt = 0;
   int l_tick = -1, s_tick = -1, lost_tick = -1;
   logic [31:0] l_ts, r_ts;
   logic l_rise_cap, r_rise_cap, dir_cap, lost_at_pulse, prev_lost;

   function automatic bit s2_at(int p, int j);
      return (j < 0) ? 1'b0 : hist[p][j];
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 4; p++) begin
         hist[p].delete();
         m_lvl[p] = 1'b0;
      end
      m_dir = 1'b0; synced = 1'b0; last_sync = 0; ts_ok = 1'b1;
   endtask

   // Level change accepted when the last FC synchronised samples all differ from lvl
   task automatic model_edge();
      bit l, r, v, same;
      int j;
      hist[0].push_back(sig_l_raw);
      hist[1].push_back(sig_r_raw);
      hist[2].push_back(lsync_raw);
      hist[3].push_back(rsync_raw);
      j = hist[0].size() - 1;
      for (int p = 0; p < 4; p++) begin
         v = s2_at(p, j - 2);
         same = 1'b1;
         for (int k = 0; k < FC; k++) if (s2_at(p, j - 2 - k) != v) same = 1'b0;
         e_edge[p] = same && (v != m_lvl[p]);
         e_rise[p] = v;
         if (e_edge[p]) m_lvl[p] = v;
      end
      l = e_edge[2] & e_rise[2];
      r = e_edge[3] & e_rise[3];
      e_sync = l | r;
      e_conf = l & r;
      if (l && !r) m_dir = 1'b0;
      if (r && !l) m_dir = 1'b1;
      if (e_sync) begin synced = 1'b1; last_sync = j; end
   endtask

   task automatic tick();
      int j;
      @(posedge clk);
      model_edge();
      j = hist[0].size() - 1;
      @(negedge clk);
      tick_no++;
      check_val("sig_l_edge", sig_l_edge, e_edge[0]);
      if (e_edge[0]) check_val("sig_l_rise", sig_l_rise, e_rise[0]);
      check_val("sig_r_edge", sig_r_edge, e_edge[1]);
      if (e_edge[1]) check_val("sig_r_rise", sig_r_rise, e_rise[1]);
      check_val("sync_pulse", sync_pulse, e_sync);
      check_val("sync_conflict", sync_conflict, e_conf);
      check_val("dir", dir, m_dir);
      check_val("sync_lost", sync_lost, (!synced || (j - last_sync >= int'(TO))) ? 1 : 0);
      if (ts_ok) check_val("timestamp", current_timestamp, j + 1);
      if (sig_l_edge) begin l_cnt++; l_tick = tick_no; l_ts = current_timestamp; l_rise_cap = sig_l_rise; end
      if (sig_r_edge) begin r_cnt++; r_ts = current_timestamp; r_rise_cap = sig_r_rise; end
      if (sync_pulse) begin s_cnt++; s_tick = tick_no; dir_cap = dir; lost_at_pulse = sync_lost; end
      if (sync_conflict) c_cnt++;
      if (sync_lost && !prev_lost) lost_tick = tick_no;
      prev_lost = sync_lost;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ts"}, current_timestamp, 32'd0);
      check_val({tag, "_edges"}, {sig_l_edge, sig_l_rise, sig_r_edge, sig_r_rise}, 4'b0000);
      check_val({tag, "_sync"}, {sync_pulse, sync_conflict, dir}, 3'b000);
      check_val({tag, "_lost"}, sync_lost, 1'b1);
   endtask

   initial begin
      int base, lc0, sc0, hold[4];
      logic [3:0] rv;
      model_reset();
      prev_lost = 1'b1;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      ticks(8);

      // Glitch of 3 samples is rejected, 4 held samples give one rising pulse
      lc0 = l_cnt;
      sig_l_raw = 1'b1; ticks(3);
      sig_l_raw = 1'b0; ticks(10);
      check_val("glitch_no_pulse", l_cnt - lc0, 0);
      base = tick_no;
      sig_l_raw = 1'b1; ticks(10);
      check_val("accept_one_pulse", l_cnt - lc0, 1);
      check_val("accept_latency", l_tick - base, 6);
      check_val("accept_rise", l_rise_cap, 1'b1);

      // Equal latency: L rises at t, R falls at t+100
      sig_l_raw = 1'b0; sig_r_raw = 1'b1; ticks(12);
      sig_l_raw = 1'b1; ticks(100);
      sig_r_raw = 1'b0; ticks(10);
      check_val("equal_latency_dts", r_ts - l_ts, 32'd100);
      check_val("equal_latency_lrise", l_rise_cap, 1'b1);
      check_val("equal_latency_rrise", r_rise_cap, 1'b0);

      // Direction tracking and ignored falling edge
      sc0 = s_cnt;
      lsync_raw = 1'b1; ticks(8);
      check_val("lsync_dir", dir_cap, 1'b0);
      lsync_raw = 1'b0; ticks(8);
      check_val("lsync_fall_ignored", s_cnt - sc0, 1);
      rsync_raw = 1'b1; ticks(8);
      check_val("rsync_dir", dir_cap, 1'b1);
      rsync_raw = 1'b0; ticks(8);

      // Conflict: both rise together with dir=1
      sc0 = s_cnt;
      lsync_raw = 1'b1; rsync_raw = 1'b1; ticks(8);
      check_val("conflict_pulses", s_cnt - sc0, 1);
      check_val("conflict_flag", c_cnt, 1);
      check_val("conflict_dir", dir_cap, 1'b1);
      lsync_raw = 1'b0; rsync_raw = 1'b0; ticks(70);

      // Watchdog: lost re-asserts TO cycles after the pulse, next sync clears it
      lost_tick = -1;
      lsync_raw = 1'b1; ticks(8);
      lsync_raw = 1'b0; ticks(60);
      check_val("watchdog_delay", lost_tick - s_tick, int'(TO));
      rsync_raw = 1'b1; ticks(8);
      check_val("watchdog_clear", lost_at_pulse, 1'b0);
      rsync_raw = 1'b0; ticks(8);

      // Randomised hold lengths on all four pins
      for (int p = 0; p < 4; p++) hold[p] = 1;
      for (int i = 0; i < 600; i++) begin
         rv = {rsync_raw, lsync_raw, sig_r_raw, sig_l_raw};
         for (int p = 0; p < 4; p++) begin
            hold[p]--;
            if (hold[p] == 0) begin
               rv[p] = 1'($urandom_range(0, 1));
               hold[p] = $urandom_range(1, 8);
            end
         end
         {rsync_raw, lsync_raw, sig_r_raw, sig_l_raw} = rv;
         tick();
      end

      // Timestamp wrap
      ts_ok = 1'b0;
      force dut.ts_r = 32'hFFFF_FFFE;
      #1;
      release dut.ts_r;
      check_val("wrap_fe", current_timestamp, 32'hFFFF_FFFE);
      tick(); check_val("wrap_ff", current_timestamp, 32'hFFFF_FFFF);
      tick(); check_val("wrap_00", current_timestamp, 32'h0000_0000);
      tick(); check_val("wrap_01", current_timestamp, 32'h0000_0001);

      // Reset in the middle of a filter count
      {rsync_raw, lsync_raw, sig_r_raw, sig_l_raw} = 4'b0000;
      ticks(12);
      sig_l_raw = 1'b1; ticks(3);
      reset_n = 1'b0; sig_l_raw = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      prev_lost = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      lc0 = l_cnt;
      ticks(12);
      check_val("midreset_no_pulse", l_cnt - lc0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/groove_edge_timestamper.md
# groove_edge_timestamper

Front-end conditioning stage of the preprocess chain; feeds `groove_sample_selector`. Conditions the raw groove comparator pins (SIG_L, SIG_R) and the end-of-sweep pins (LSYNC, RSYNC). For each pin it applies a two-flop synchroniser and a stability glitch filter, then emits single-cycle edge pulses with polarity. It also provides the free-running timestamp, the merged sync pulse and the derived scan direction, and flags lost or conflicting sync.

## Interface
Parameters:
- FILTER_CYCLES, 4, consecutive stable synchronised samples required to accept a level change; legal range 1..255
- SYNC_TIMEOUT, 32'd5_000_000, cycles without an accepted sync before `sync_lost` asserts; must be ≥2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sig_l_raw  in  1  left groove comparator, asynchronous
- sig_r_raw  in  1  right groove comparator, asynchronous
- lsync_raw  in  1  left end-of-sweep marker, asynchronous
- rsync_raw  in  1  right end-of-sweep marker, asynchronous
- current_timestamp  out  32  free-running cycle counter
- sig_l_edge  out  1  one-cycle pulse on an accepted SIG_L transition
- sig_l_rise  out  1  polarity of that transition (1 = rising); valid only with `sig_l_edge`
- sig_r_edge  out  1  one-cycle pulse on an accepted SIG_R transition
- sig_r_rise  out  1  polarity of that transition; valid only with `sig_r_edge`
- sync_pulse  out  1  one-cycle pulse on an accepted rising edge of LSYNC or RSYNC
- dir  out  1  direction of the sweep now starting: 0 = LTR, 1 = RTL
- sync_lost  out  1  level; no accepted sync within SYNC_TIMEOUT
- sync_conflict  out  1  one-cycle pulse when LSYNC and RSYNC are accepted in the same cycle

## Operation
- **Per-pin chain** (×4): s1 ← raw; s2 ← s1; filter; edge detect.
- **Filter state:** accepted level `lvl` and counter `cnt` (8 bits).
  - If s2 == lvl: cnt ← 0.
  - Else if cnt == FILTER_CYCLES−1: lvl ← s2, cnt ← 0, and the edge pulse plus polarity (= s2) are registered in the same cycle.
  - Else: cnt ← cnt+1.
- **Glitches:** a glitch shorter than FILTER_CYCLES synchronised samples produces no pulse. Each accepted level change produces exactly one pulse.
- **Timestamp:** increments every cycle and wraps from 0xFFFFFFFF to 0 with no flag. Downstream computes differences modulo 2^32.
- **Sync:** only rising accepted edges on LSYNC or RSYNC count; falling edges are ignored.
  - LSYNC rise: `sync_pulse`=1, dir ← 0 (scanner at left, next sweep LTR).
  - RSYNC rise: `sync_pulse`=1, dir ← 1.
  - Both in the same cycle: one `sync_pulse`, dir unchanged, `sync_conflict`=1.
- **dir update:** dir changes on the same clock that registers `sync_pulse`, so `dir` is already the new value during the pulse cycle.
- **Sync watchdog:** 32-bit counter cleared on every accepted sync, otherwise increments and saturates at SYNC_TIMEOUT.
  - `sync_lost` asserts when the counter reaches SYNC_TIMEOUT.
  - `sync_lost` clears on the cycle `sync_pulse` asserts.
- **Independence:** groove edges and sync are independent. A SIG edge and `sync_pulse` may pulse in the same cycle, and both are output unmodified.

## Timing
- **Reset values:** every s1/s2/lvl = 0, cnt = 0, `current_timestamp` = 0, all edge/rise/`sync_pulse`/`sync_conflict` = 0, `dir` = 0, `sync_lost` = 1, watchdog = 0.
- **Latency:** a raw change first sampled at clock edge n produces an edge pulse visible after edge n+1+FILTER_CYCLES (FILTER_CYCLES+2 cycles). This is identical on all four pins, so L/R timestamp differences are unbiased.
- **Pulse width:** exactly 1 cycle. The minimum spacing between pulses on one pin is FILTER_CYCLES cycles.
- **High pin at reset release:** a pin already high when reset releases yields one rising pulse at cycle FILTER_CYCLES+2. This is required behaviour; downstream discards it by polarity or sweep.
- **Reset mid-operation:** all state returns immediately to reset values (asynchronous); no pulse is generated on assertion or release beyond the case above.
- **Watchdog timing:** starting from reset with no sync, `sync_lost` stays 1. After the first sync, `sync_lost` re-asserts exactly SYNC_TIMEOUT cycles after the last `sync_pulse` cycle.

## Structure
- **Shared package `groove_pkg`:** TS_WIDTH = 32, DIR_LTR = 1'b0, DIR_RTL = 1'b1. Also used by `groove_sample_selector`.
- **Sub-module `groove_pin_filter`** (parameter FILTER_CYCLES): synchroniser, filter and edge detect, with outputs `lvl`, `edge_pulse` and `rise`. Instantiated four times.
- **Top level:** timestamp counter, sync merge, dir register and watchdog.

## Test plan
- **Glitch rejection:** FILTER_CYCLES=4; SIG_L high for 3 cycles then low -> no `sig_l_edge`. Held high 4 cycles -> one pulse with `sig_l_rise`=1 at the 6th clock after first sampling.
- **Equal latency:** SIG_L rise at t, SIG_R fall at t+100 -> pulses 100 cycles apart with rise=1 and rise=0 respectively. Timestamps differ by 100.
- **Direction tracking:** LSYNC pulse -> `sync_pulse`, dir=0 in the same cycle. Then RSYNC -> dir=1. An LSYNC falling edge alone -> no `sync_pulse`.
- **Conflict:** LSYNC and RSYNC raised on the same clock with dir=1 -> single `sync_pulse`, `sync_conflict`=1, dir stays 1.
- **Watchdog:** SYNC_TIMEOUT=50; sync then silence -> `sync_lost` 0→1 exactly 50 cycles after the pulse. The next sync clears it on the pulse cycle.
- **Wrap and reset:** force the timestamp to 0xFFFFFFFE -> sequence FE, FF, 0, 1. Assert reset_n mid-filter-count -> all outputs at reset values and no pulse emitted.
